// File: rtl/resize_ctrl_pkg.sv
// Shared types and constants for the bicubic resize frame controller.
package resize_ctrl_pkg;

    localparam int unsigned W_BITS   = 12;
    localparam int unsigned H_BITS   = 11;
    localparam int unsigned PIX_BITS = 24;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CFG     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [W_BITS-1:0] width;
        logic [H_BITS-1:0] height;
        logic              up;
        logic [3:0]        x_scale;
        logic [3:0]        y_scale;
    } cfg_t;

endpackage

// File: rtl/resize_frame_ctrl_if.sv
// Pixel stream bundle: upstream s_* into the controller, framed m_* out of it.
interface resize_frame_ctrl_if;
    import resize_ctrl_pkg::*;

    logic                s_valid;
    logic [PIX_BITS-1:0] s_data;
    logic                s_ready;
    logic                m_valid;
    logic [PIX_BITS-1:0] m_data;
    logic                m_sof;
    logic                m_eol;
    logic                m_eof;

    // slave = controller view, master = stream source / sink view
    modport slave  (input  s_valid, s_data, output s_ready, m_valid, m_data, m_sof, m_eol, m_eof);
    modport master (output s_valid, s_data, input  s_ready, m_valid, m_data, m_sof, m_eol, m_eof);

endinterface

// File: rtl/resize_div_ceil.sv
// Sequential restoring divider: W cycles after start, quotient = ceil(dividend/divisor).
module resize_div_ceil
    import resize_ctrl_pkg::*;
#(
    parameter int unsigned W = W_BITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  quo_q, quo_d, div_q, div_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [W:0]    trial;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        trial  = '0;
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            div_d  = divisor;
            cnt_d  = CW'(W);
            done_d = 1'b0;
        end else if (cnt_q != '0) begin
            trial = {rem_q, quo_q[W-1]};
            if (trial >= {1'b0, div_q}) begin
                rem_d = trial[W-1:0] - div_q;
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = trial[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d  = cnt_q - 1'b1;
            done_d = (cnt_q == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q + {{(W-1){1'b0}}, (rem_q != '0)};

endmodule

// File: rtl/resize_frame_ctrl.sv
// Frame sequencer for the bicubic resize core: cfg shadowing, flush, input gating, output framing.
// Optional drain watchdog enabled by defining RESIZE_CTRL_TIMEOUT_EN.
module resize_frame_ctrl
    import resize_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_wr,
    input  logic [W_BITS-1:0]   cfg_width,
    input  logic [H_BITS-1:0]   cfg_height,
    input  logic                cfg_up_flag,
    input  logic [3:0]          cfg_x_scale,
    input  logic [3:0]          cfg_y_scale,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err,
    output logic                core_reset,
    output logic [W_BITS-1:0]   img_width,
    output logic [H_BITS-1:0]   img_height,
    output logic                up_flag,
    output logic [3:0]          x_scale_factor,
    output logic [3:0]          y_scale_factor,
    resize_frame_ctrl_if.slave  px,
    output logic                core_valid_i,
    output logic [PIX_BITS-1:0] core_data_i,
    input  logic                core_wr_ready,
    input  logic                core_valid_o,
    input  logic [PIX_BITS-1:0] core_data_o
);
    localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);

    state_e              state_q, state_d;
    cfg_t                shadow_q, shadow_d, active_q, active_d;
    logic [1:0]          err_q, err_d;
    logic [FCW-1:0]      flush_cnt_q, flush_cnt_d;
    logic [22:0]         in_cnt_q, in_cnt_d, total_in;
    logic [30:0]         out_cnt_q, out_cnt_d, total_out;
    logic [15:0]         col_q, col_d, out_w;
    logic [14:0]         row_q, row_d, out_h;
    logic                m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eol_q, m_eol_d, m_eof_q, m_eof_d;
    logic [PIX_BITS-1:0] m_data_q, m_data_d;
    logic                s_ready_c, pix_ok, cfg_legal, div_start, timeout_hit;
    logic                dx_done, dy_done;
    logic [W_BITS-1:0]   dx_q;
    logic [H_BITS-1:0]   dy_q;

    assign cfg_legal = (shadow_q.width >= W_BITS'(4)) && (shadow_q.height >= H_BITS'(4)) &&
                       (shadow_q.x_scale != '0) && (shadow_q.y_scale != '0) &&
                       (shadow_q.up || (({8'b0, shadow_q.x_scale} <= shadow_q.width) &&
                                        ({7'b0, shadow_q.y_scale} <= shadow_q.height)));
    assign div_start = (state_q == IDLE) && start && cfg_legal;

    // Both dividers latch the shadow operands on the accepting start and run during FLUSH.
    resize_div_ceil #(.W(W_BITS)) u_div_x (
        .clk(clk), .reset(reset), .start(div_start),
        .dividend(shadow_q.width), .divisor({8'b0, shadow_q.x_scale}),
        .done(dx_done), .quotient(dx_q)
    );
    resize_div_ceil #(.W(H_BITS)) u_div_y (
        .clk(clk), .reset(reset), .start(div_start),
        .dividend(shadow_q.height), .divisor({7'b0, shadow_q.y_scale}),
        .done(dy_done), .quotient(dy_q)
    );

    assign out_w     = active_q.up ? ({4'b0, active_q.width} * {12'b0, active_q.x_scale}) : {4'b0, dx_q};
    assign out_h     = active_q.up ? ({4'b0, active_q.height} * {11'b0, active_q.y_scale}) : {4'b0, dy_q};
    assign total_in  = {11'b0, active_q.width} * {12'b0, active_q.height};
    assign total_out = {15'b0, out_w} * {16'b0, out_h};

`ifdef RESIZE_CTRL_TIMEOUT_EN
    logic [16:0] wd_q, wd_d;

    always_comb begin
        wd_d        = '0;
        timeout_hit = 1'b0;
        if (state_q == DRAIN && !core_valid_o) begin
            wd_d        = wd_q + 17'd1;
            timeout_hit = (wd_d == 17'(TIMEOUT_CYCLES));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    // Watchdog compiled out; the parameter is kept so overrides still elaborate.
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        err_d       = err_q;
        flush_cnt_d = flush_cnt_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        m_valid_d   = 1'b0;
        m_sof_d     = 1'b0;
        m_eol_d     = 1'b0;
        m_eof_d     = 1'b0;
        m_data_d    = m_data_q;
        s_ready_c   = 1'b0;

        if (cfg_wr) shadow_d = '{width: cfg_width, height: cfg_height, up: cfg_up_flag,
                                 x_scale: cfg_x_scale, y_scale: cfg_y_scale};

        pix_ok = core_valid_o && (state_q == RUN || state_q == DRAIN) && (out_cnt_q < total_out);
        if (pix_ok) begin
            m_valid_d = 1'b1;
            m_data_d  = core_data_o;
            m_sof_d   = (col_q == '0) && (row_q == '0);
            m_eol_d   = (col_q == out_w - 16'd1);
            m_eof_d   = m_eol_d && (row_q == out_h - 15'd1);
            out_cnt_d = out_cnt_q + 31'd1;
            if (m_eol_d) begin
                col_d = '0;
                row_d = (row_q == out_h - 15'd1) ? '0 : row_q + 15'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end

        unique case (state_q)
            IDLE: if (start) begin
                if (cfg_legal) begin
                    state_d     = FLUSH;
                    active_d    = shadow_q;
                    err_d       = ERR_NONE;
                    flush_cnt_d = '0;
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    col_d       = '0;
                    row_d       = '0;
                end else begin
                    err_d = ERR_CFG;
                end
            end
            FLUSH: begin
                if (flush_cnt_q != FCW'(FLUSH_CYCLES)) flush_cnt_d = flush_cnt_q + 1'b1;
                else if (dx_done && dy_done)           state_d     = RUN;
            end
            RUN: begin
                s_ready_c = core_wr_ready && (in_cnt_q < total_in);
                if (px.s_valid && s_ready_c) in_cnt_d = in_cnt_q + 23'd1;
                if (in_cnt_d >= total_in) state_d = DRAIN;
            end
            DRAIN: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = ERR_TIMEOUT;
                end else if (out_cnt_d >= total_out) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            err_q       <= ERR_NONE;
            flush_cnt_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            m_valid_q   <= 1'b0;
            m_sof_q     <= 1'b0;
            m_eol_q     <= 1'b0;
            m_eof_q     <= 1'b0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            err_q       <= err_d;
            flush_cnt_q <= flush_cnt_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            m_valid_q   <= m_valid_d;
            m_sof_q     <= m_sof_d;
            m_eol_q     <= m_eol_d;
            m_eof_q     <= m_eof_d;
            m_data_q    <= m_data_d;
        end
    end

    assign busy           = (state_q == FLUSH) || (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
    assign core_reset     = (state_q == IDLE) || ((state_q == FLUSH) && (flush_cnt_q < FCW'(FLUSH_CYCLES)));
    assign err            = err_q;
    assign img_width      = active_q.width;
    assign img_height     = active_q.height;
    assign up_flag        = active_q.up;
    assign x_scale_factor = active_q.x_scale;
    assign y_scale_factor = active_q.y_scale;
    assign px.s_ready     = s_ready_c;
    assign px.m_valid     = m_valid_q;
    assign px.m_data      = m_data_q;
    assign px.m_sof       = m_sof_q;
    assign px.m_eol       = m_eol_q;
    assign px.m_eof       = m_eof_q;
    assign core_valid_i   = px.s_valid && s_ready_c;
    assign core_data_i    = px.s_data;

endmodule
